// File: rtl/onchip_memory_dp.sv
// rtl/onchip_memory_dp.sv - dual-port byte-enabled on-chip RAM with pipelined, stallable reads
// Optional zero-fill clear engine after reset: define ONCHIP_MEMORY_DP_CLEAR_EN.
module onchip_memory_dp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic                  ce;
  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign ce = clken & ~reset_req;

`ifdef ONCHIP_MEMORY_DP_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_e;
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else if (state_q == CLEAR && ce) begin
      clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
      if (&clr_cnt_q) state_q <= IDLE;
    end
  end

  // Reset is included so masters are held off before the FSM has entered CLEAR.
  assign busy     = reset | (state_q == CLEAR);
  assign clr_we   = ~reset & (state_q == CLEAR) & ce;
  assign clr_addr = clr_cnt_q;
`else
  assign busy     = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  logic [1:0]            wr_en;
  logic [1:0]            rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr [2];

  // Read+write together is a write; reads during reset are never launched.
  always_comb begin
    wr_en[0]   = s1_chipselect & ce & ~busy & s1_write;
    wr_en[1]   = s2_chipselect & ce & ~busy & s2_write;
    rd_en[0]   = s1_chipselect & ce & ~busy & s1_read & ~s1_write & ~reset;
    rd_en[1]   = s2_chipselect & ce & ~busy & s2_read & ~s2_write & ~reset;
    rd_addr[0] = s1_address;
    rd_addr[1] = s2_address;
  end

  // s1 lanes are written last so they win on an overlapping same-address write.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_en[1] && s2_byteenable[b]) mem_q[s2_address][8*b +: 8] <= s2_writedata[8*b +: 8];
      if (wr_en[0] && s1_byteenable[b]) mem_q[s1_address][8*b +: 8] <= s1_writedata[8*b +: 8];
    end
    if (clr_we) mem_q[clr_addr] <= '0;
  end

  logic [DATA_WIDTH-1:0] p1_data_q  [2];
  logic [DATA_WIDTH-1:0] p1_data_d  [2];
  logic [DATA_WIDTH-1:0] out_data_q [2];
  logic [DATA_WIDTH-1:0] out_data_d [2];
  logic [1:0]            p1_valid_q, p1_valid_d;
  logic [1:0]            out_valid_q, out_valid_d;

  // Every pipeline register holds while ce=0, so stalled reads are neither lost nor repeated.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      p1_data_d[p]   = p1_data_q[p];
      p1_valid_d[p]  = p1_valid_q[p];
      out_data_d[p]  = out_data_q[p];
      out_valid_d[p] = out_valid_q[p];
      if (ce) begin
        if (READ_LATENCY == 1) begin
          p1_valid_d[p]  = 1'b0;
          out_valid_d[p] = rd_en[p];
          if (rd_en[p]) out_data_d[p] = mem_q[rd_addr[p]];
        end else begin
          p1_valid_d[p]  = rd_en[p];
          if (rd_en[p]) p1_data_d[p] = mem_q[rd_addr[p]];
          out_valid_d[p] = p1_valid_q[p];
          if (p1_valid_q[p]) out_data_d[p] = p1_data_q[p];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_valid_q  <= '0;
      out_valid_q <= '0;
      for (int p = 0; p < 2; p++) begin
        p1_data_q[p]  <= '0;
        out_data_q[p] <= '0;
      end
    end else begin
      p1_valid_q  <= p1_valid_d;
      out_valid_q <= out_valid_d;
      for (int p = 0; p < 2; p++) begin
        p1_data_q[p]  <= p1_data_d[p];
        out_data_q[p] <= out_data_d[p];
      end
    end
  end

  // The valid pulse is consumed only in a ce=1 cycle; a stalled pulse is shown when ce returns.
  assign s1_readdata      = reset ? '0 : out_data_q[0];
  assign s2_readdata      = reset ? '0 : out_data_q[1];
  assign s1_readdatavalid = out_valid_q[0] & ce & ~reset;
  assign s2_readdatavalid = out_valid_q[1] & ce & ~reset;
  assign s1_waitrequest   = busy;
  assign s2_waitrequest   = busy;

endmodule

// File: tb/tb_onchip_memory_dp.sv
// tb/tb_onchip_memory_dp.sv - directed self-checking bench for onchip_memory_dp
// Instance a: defaults (latency 1); instance b: ADDR_WIDTH=4, READ_LATENCY=2.
module tb_onchip_memory_dp;
`ifdef ONCHIP_MEMORY_DP_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        a_reset, a_clken, a_reset_req;
  logic [9:0]  a_s1_address, a_s2_address;
  logic [3:0]  a_s1_byteenable, a_s2_byteenable;
  logic        a_s1_chipselect, a_s1_read, a_s1_write;
  logic        a_s2_chipselect, a_s2_read, a_s2_write;
  logic [31:0] a_s1_writedata, a_s2_writedata, a_s1_readdata, a_s2_readdata;
  logic        a_s1_readdatavalid, a_s2_readdatavalid, a_s1_waitrequest, a_s2_waitrequest;

  logic        b_reset, b_clken, b_reset_req;
  logic [3:0]  b_s1_address, b_s2_address;
  logic [3:0]  b_s1_byteenable, b_s2_byteenable;
  logic        b_s1_chipselect, b_s1_read, b_s1_write;
  logic        b_s2_chipselect, b_s2_read, b_s2_write;
  logic [31:0] b_s1_writedata, b_s2_writedata, b_s1_readdata, b_s2_readdata;
  logic        b_s1_readdatavalid, b_s2_readdatavalid, b_s1_waitrequest, b_s2_waitrequest;

  onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .READ_LATENCY(1)) dut_a (
    .clk(clk), .reset(a_reset), .clken(a_clken), .reset_req(a_reset_req),
    .s1_address(a_s1_address), .s1_byteenable(a_s1_byteenable), .s1_chipselect(a_s1_chipselect),
    .s1_read(a_s1_read), .s1_write(a_s1_write), .s1_writedata(a_s1_writedata),
    .s1_readdata(a_s1_readdata), .s1_readdatavalid(a_s1_readdatavalid), .s1_waitrequest(a_s1_waitrequest),
    .s2_address(a_s2_address), .s2_byteenable(a_s2_byteenable), .s2_chipselect(a_s2_chipselect),
    .s2_read(a_s2_read), .s2_write(a_s2_write), .s2_writedata(a_s2_writedata),
    .s2_readdata(a_s2_readdata), .s2_readdatavalid(a_s2_readdatavalid), .s2_waitrequest(a_s2_waitrequest)
  );

  onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2)) dut_b (
    .clk(clk), .reset(b_reset), .clken(b_clken), .reset_req(b_reset_req),
    .s1_address(b_s1_address), .s1_byteenable(b_s1_byteenable), .s1_chipselect(b_s1_chipselect),
    .s1_read(b_s1_read), .s1_write(b_s1_write), .s1_writedata(b_s1_writedata),
    .s1_readdata(b_s1_readdata), .s1_readdatavalid(b_s1_readdatavalid), .s1_waitrequest(b_s1_waitrequest),
    .s2_address(b_s2_address), .s2_byteenable(b_s2_byteenable), .s2_chipselect(b_s2_chipselect),
    .s2_read(b_s2_read), .s2_write(b_s2_write), .s2_writedata(b_s2_writedata),
    .s2_readdata(b_s2_readdata), .s2_readdatavalid(b_s2_readdatavalid), .s2_waitrequest(b_s2_waitrequest)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic a_cmd1(input logic rd, input logic wr, input logic [9:0] ad, input logic [3:0] be, input logic [31:0] wd);
    a_s1_chipselect = rd | wr; a_s1_read = rd; a_s1_write = wr;
    a_s1_address = ad; a_s1_byteenable = be; a_s1_writedata = wd;
  endtask

  task automatic a_cmd2(input logic rd, input logic wr, input logic [9:0] ad, input logic [3:0] be, input logic [31:0] wd);
    a_s2_chipselect = rd | wr; a_s2_read = rd; a_s2_write = wr;
    a_s2_address = ad; a_s2_byteenable = be; a_s2_writedata = wd;
  endtask

  task automatic b_cmd1(input logic rd, input logic wr, input logic [3:0] ad, input logic [3:0] be, input logic [31:0] wd);
    b_s1_chipselect = rd | wr; b_s1_read = rd; b_s1_write = wr;
    b_s1_address = ad; b_s1_byteenable = be; b_s1_writedata = wd;
  endtask

  task automatic a_idle;
    a_cmd1(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    a_cmd2(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
  endtask

  task automatic b_idle;
    b_cmd1(1'b0, 1'b0, 4'h0, 4'h0, 32'h0);
    b_s2_chipselect = 1'b0; b_s2_read = 1'b0; b_s2_write = 1'b0;
    b_s2_address = 4'h0; b_s2_byteenable = 4'h0; b_s2_writedata = 32'h0;
  endtask

  task automatic wait_ready;
    int n = 0;
    while ((a_s1_waitrequest || b_s1_waitrequest) && n < 3000) begin
      cyc();
      n++;
    end
    checks++;
    if (a_s1_waitrequest !== 1'b0 || b_s1_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL wait_ready: waitrequest a=%b b=%b still high, required 0", a_s1_waitrequest, b_s1_waitrequest);
    end
  endtask

  task automatic test_reset;
    a_reset = 1'b1; b_reset = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    checks++; if (a_s1_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_s1_valid: got %b required 0", a_s1_readdatavalid); end
    checks++; if (a_s2_readdatavalid !== 1'b0) begin errors++; $display("FAIL reset_s2_valid: got %b required 0", a_s2_readdatavalid); end
    checks++; if (a_s1_readdata !== 32'h0) begin errors++; $display("FAIL reset_s1_data: got %h required 0", a_s1_readdata); end
    checks++; if (a_s1_waitrequest !== CLR) begin errors++; $display("FAIL reset_waitrequest: got %b required %b", a_s1_waitrequest, CLR); end
    cyc();
    a_reset = 1'b0; b_reset = 1'b0;
    wait_ready();
  endtask

  task automatic test_write_read;
    a_cmd1(1'b0, 1'b1, 10'h005, 4'hF, 32'hDEADBEEF);
    cyc();
    a_cmd1(1'b1, 1'b0, 10'h005, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (a_s1_readdatavalid !== 1'b0) begin errors++; $display("FAIL wr_no_valid: got %b required 0", a_s1_readdatavalid); end
    cyc();
    a_idle();
    @(negedge clk);
    checks++; if (a_s1_readdatavalid !== 1'b1) begin errors++; $display("FAIL rd_latency_valid: got %b required 1", a_s1_readdatavalid); end
    checks++; if (a_s1_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h required deadbeef", a_s1_readdata); end
    cyc();
    @(negedge clk);
    checks++; if (a_s1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rd_single_pulse: got %b required 0", a_s1_readdatavalid); end
    checks++; if (a_s1_readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_hold: got %h required deadbeef", a_s1_readdata); end
    a_cmd1(1'b0, 1'b1, 10'h005, 4'h5, 32'h00112233);
    cyc();
    a_idle();
    a_cmd2(1'b1, 1'b0, 10'h005, 4'h0, 32'h0);
    cyc();
    a_idle();
    @(negedge clk);
    checks++; if (a_s2_readdatavalid !== 1'b1 || a_s2_readdata !== 32'hDE11BE33) begin errors++; $display("FAIL byteenable: got v=%b %h required v=1 de11be33", a_s2_readdatavalid, a_s2_readdata); end
    a_cmd1(1'b1, 1'b1, 10'h006, 4'hF, 32'h11111111);
    cyc();
    a_idle();
    @(negedge clk);
    checks++; if (a_s1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rw_is_write: got valid %b required 0", a_s1_readdatavalid); end
    a_cmd1(1'b1, 1'b0, 10'h006, 4'h0, 32'h0);
    cyc();
    a_idle();
    @(negedge clk);
    checks++; if (a_s1_readdata !== 32'h11111111) begin errors++; $display("FAIL rw_written: got %h required 11111111", a_s1_readdata); end
    cyc();
  endtask

  task automatic test_collision;
    a_cmd1(1'b0, 1'b1, 10'h010, 4'hF, 32'h00000000);
    cyc();
    a_cmd1(1'b0, 1'b1, 10'h010, 4'h3, 32'hAAAAAAAA);
    a_cmd2(1'b0, 1'b1, 10'h010, 4'h6, 32'h55555555);
    cyc();
    a_idle();
    a_cmd1(1'b1, 1'b0, 10'h010, 4'h0, 32'h0);
    cyc();
    a_idle();
    @(negedge clk);
    checks++; if (a_s1_readdatavalid !== 1'b1 || a_s1_readdata !== 32'h0055AAAA) begin errors++; $display("FAIL collision: got v=%b %h required v=1 0055aaaa", a_s1_readdatavalid, a_s1_readdata); end
    cyc();
  endtask

  task automatic test_read_during_write;
    a_cmd1(1'b0, 1'b1, 10'h020, 4'hF, 32'h0);
    cyc();
    a_cmd1(1'b0, 1'b1, 10'h020, 4'hF, 32'h12345678);
    a_cmd2(1'b1, 1'b0, 10'h020, 4'h0, 32'h0);
    cyc();
    a_cmd1(1'b0, 1'b0, 10'h0, 4'h0, 32'h0);
    @(negedge clk);
    checks++; if (a_s2_readdatavalid !== 1'b1 || a_s2_readdata !== 32'h0) begin errors++; $display("FAIL rdw_old_data: got v=%b %h required v=1 00000000", a_s2_readdatavalid, a_s2_readdata); end
    cyc();
    a_idle();
    @(negedge clk);
    checks++; if (a_s2_readdatavalid !== 1'b1 || a_s2_readdata !== 32'h12345678) begin errors++; $display("FAIL rdw_new_data: got v=%b %h required v=1 12345678", a_s2_readdatavalid, a_s2_readdata); end
    cyc();
  endtask

  task automatic test_clken_stall;
    logic        ce_t [10];
    logic        rd_t [10];
    logic [9:0]  ad_t [10];
    logic [31:0] got [$];
    int          bad = 0;
    ce_t = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    rd_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ad_t = '{10'h030, 10'h031, 10'h032, 10'h032, 10'h032, 10'h032, 10'h033, 10'h0, 10'h0, 10'h0};
    for (int i = 0; i < 4; i++) begin
      a_cmd1(1'b0, 1'b1, 10'(10'h030 + i), 4'hF, 32'hA0000000 + 32'(i));
      cyc();
    end
    for (int i = 0; i < 10; i++) begin
      a_clken = ce_t[i];
      a_cmd1(rd_t[i], 1'b0, ad_t[i], 4'h0, 32'h0);
      @(negedge clk);
      if (a_s1_readdatavalid === 1'b1) begin
        if (a_clken !== 1'b1) bad++;
        got.push_back(a_s1_readdata);
      end
      cyc();
    end
    a_clken = 1'b1;
    a_idle();
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_valid_while_off: got %0d pulses with clken=0 required 0", bad); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL stall_pulse_count: got %0d required 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      checks++;
      if (got[k] !== 32'hA0000000 + 32'(k)) begin errors++; $display("FAIL stall_order[%0d]: got %h required %h", k, got[k], 32'hA0000000 + 32'(k)); end
    end
  endtask

  task automatic test_latency2_reset;
    b_cmd1(1'b0, 1'b1, 4'h3, 4'hF, 32'hCAFEF00D);
    cyc();
    b_cmd1(1'b1, 1'b0, 4'h3, 4'h0, 32'h0);
    cyc();
    b_idle();
    @(negedge clk);
    checks++; if (b_s1_readdatavalid !== 1'b0) begin errors++; $display("FAIL lat2_early: got %b required 0", b_s1_readdatavalid); end
    cyc();
    @(negedge clk);
    checks++; if (b_s1_readdatavalid !== 1'b1 || b_s1_readdata !== 32'hCAFEF00D) begin errors++; $display("FAIL lat2_data: got v=%b %h required v=1 cafef00d", b_s1_readdatavalid, b_s1_readdata); end
    cyc();
    b_cmd1(1'b1, 1'b0, 4'h3, 4'h0, 32'h0);
    cyc();
    b_idle();
    b_reset = 1'b1;
    @(negedge clk);
    checks++; if (b_s1_readdatavalid !== 1'b0 || b_s1_readdata !== 32'h0) begin errors++; $display("FAIL midread_reset_out: got v=%b %h required v=0 00000000", b_s1_readdatavalid, b_s1_readdata); end
    cyc();
    b_reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (b_s1_readdatavalid !== 1'b0 || b_s1_readdata !== 32'h0) begin errors++; $display("FAIL midread_flushed[%0d]: got v=%b %h required v=0 00000000", i, b_s1_readdatavalid, b_s1_readdata); end
      cyc();
    end
    wait_ready();
  endtask

  task automatic test_clear;
    int          nwait = 0;
    logic [31:0] exp_d;
    exp_d = CLR ? 32'h0 : 32'hFFFFFFFF;
    for (int i = 0; i < 16; i++) begin
      b_cmd1(1'b0, 1'b1, 4'(i), 4'hF, 32'hFFFFFFFF);
      cyc();
    end
    b_idle();
    b_reset = 1'b1;
    @(negedge clk);
    checks++; if (b_s2_waitrequest !== CLR) begin errors++; $display("FAIL clear_wait_in_reset: got %b required %b", b_s2_waitrequest, CLR); end
    cyc();
    b_reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (b_s1_waitrequest === 1'b1) nwait++;
      cyc();
    end
    checks++; if (nwait != (CLR ? 16 : 0)) begin errors++; $display("FAIL clear_wait_cycles: got %0d required %0d", nwait, CLR ? 16 : 0); end
    for (int i = 0; i < 18; i++) begin
      if (i < 16) b_cmd1(1'b1, 1'b0, 4'(i), 4'h0, 32'h0);
      else b_idle();
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (b_s1_readdatavalid !== 1'b1 || b_s1_readdata !== exp_d) begin errors++; $display("FAIL clear_read[%0d]: got v=%b %h required v=1 %h", i - 2, b_s1_readdatavalid, b_s1_readdata, exp_d); end
      end
      cyc();
    end
    b_idle();
  endtask

  initial begin
    a_reset = 1'b1; a_clken = 1'b1; a_reset_req = 1'b0;
    b_reset = 1'b1; b_clken = 1'b1; b_reset_req = 1'b0;
    a_idle();
    b_idle();
    test_reset();
    test_write_read();
    test_collision();
    test_read_during_write();
    test_clken_stall();
    test_latency2_reset();
    test_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
